// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a one-hot plus encoded grant and an
// optional hold limit that forces the owner off the shared resource.
//
// state | meaning
// IDLE  | no grant active; arbitrate on the next edge if enabled
// GRANT | one requester owns the resource; watch for release causes
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q,    state_d;
    logic [2:0]       ptr_q,      ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       gnt_q,      gnt_d;
    logic [2:0]       gnt_idx_q,  gnt_idx_d;
    logic             gnt_vld_q,  gnt_vld_d;
    logic             timeout_q,  timeout_d;

    logic             pick_found;
    logic [2:0]       pick_idx;
    logic             limit_hit;
    logic             owner_drop;
    logic             release_now;

    // First set request at or after ptr, wrapping modulo 8.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!pick_found && req[ptr_q + 3'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 3'(i);
            end
        end
    end

    assign limit_hit   = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
    assign owner_drop  = !req[gnt_idx_q];
    assign release_now = done || owner_drop || !en || limit_hit;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d     = 8'h00;
                gnt_idx_d = 3'd0;
                gnt_vld_d = 1'b0;
                if (en && pick_found) begin
                    gnt_d      = 8'b1 << pick_idx;
                    gnt_idx_d  = pick_idx;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d     = 8'h00;
                    gnt_idx_d = 3'd0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + 3'd1;
                    // Flag a forced release only when nothing else ended the grant.
                    timeout_d = limit_hit && !done && !owner_drop && en;
                    state_d   = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
            gnt_q      <= 8'h00;
            gnt_idx_q  <= 3'd0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with a short hold limit so the forced
// release path is reachable in a few cycles.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 #(.HOLD_MAX(4), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] idx);
        chk({tag, "_vld"}, {7'd0, gnt_vld}, 8'h01);
        chk({tag, "_idx"}, {5'd0, gnt_idx}, {5'd0, idx});
        chk({tag, "_gnt"}, gnt, 8'b1 << idx);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_vld"}, {7'd0, gnt_vld}, 8'h00);
        chk({tag, "_gnt"}, gnt, 8'h00);
        chk({tag, "_idx"}, {5'd0, gnt_idx}, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        step();
        step();
        chk_idle("rst");
        chk("rst_to", {7'd0, timeout}, 8'h00);
        rst_n = 1'b1;
    endtask

    // Pulse done for one edge and confirm the grant is gone afterwards.
    task automatic release_done(input string tag);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_idle(tag);
    endtask

    initial begin
        do_reset();

        // Single request, then pointer moves past the released owner.
        en  = 1'b1;
        req = 8'b0000_0100;
        step();
        chk_grant("single", 3'd2);
        release_done("single_rel");
        req = 8'b0000_1100;
        step();
        chk_grant("ptr3", 3'd3);
        release_done("ptr3_rel");
        req = 8'h00;
        step();

        // Full rotation from a fresh pointer.
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk_grant("rot", 3'(k % 8));
            release_done("rot_gap");
        end
        req = 8'h00;
        step();

        // Wrap-around priority: 6 then 7 then 0.
        req = 8'h40;
        step();
        chk_grant("g6", 3'd6);
        release_done("g6_rel");
        req = 8'b1000_0001;
        step();
        chk_grant("wrap7", 3'd7);
        release_done("wrap7_rel");
        step();
        chk_grant("wrap0", 3'd0);
        release_done("wrap0_rel");
        req = 8'h00;
        step();

        // Hold limit of 4 cycles with a sole requester.
        req = 8'h40;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_grant("hold", 3'd6);
            chk("hold_to", {7'd0, timeout}, 8'h00);
        end
        step();
        chk_idle("to_rel");
        chk("to_pulse", {7'd0, timeout}, 8'h01);
        step();
        chk("to_end", {7'd0, timeout}, 8'h00);
        chk_grant("to_regrant", 3'd6);

        // done coinciding with the limit suppresses the timeout flag.
        step();
        step();
        step();
        chk_grant("coinc_hold", 3'd6);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_idle("coinc_rel");
        chk("coinc_to", {7'd0, timeout}, 8'h00);
        req = 8'h00;
        step();

        // Enable withdrawal; ptr is 7 so requester 1 wins.
        req = 8'b0000_0010;
        step();
        chk_grant("en_g1", 3'd1);
        en = 1'b0;
        step();
        chk_idle("en_off");
        step();
        step();
        chk_idle("en_off_hold");
        en = 1'b1;
        step();
        chk_grant("en_back", 3'd1);

        // Owner drops its request; pointer moves to owner+1.
        req = 8'b0000_1100;
        step();
        chk_idle("drop_rel");
        chk("drop_to", {7'd0, timeout}, 8'h00);
        step();
        chk_grant("drop_next", 3'd2);
        release_done("drop_next_rel");
        req = 8'h00;
        step();

        // Asynchronous reset while requester 5 owns the grant.
        req = 8'h20;
        step();
        chk_grant("g5", 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        req = 8'hFF;
        #3;
        rst_n = 1'b1;
        step();
        chk_grant("post_rst", 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
